uart_rx_word_assembler: RTL and testbench

- Sits directly downstream of the UART byte receiver and upstream of the operand register feeding the adder/ALU.
- Collects NUM_BYTES consecutive received bytes, little-endian, into one wide word and presents it with a valid/ready handshake.
- With NUM_BYTES=8, bytes 0-3 form operand A in bits [31:0] and bytes 4-7 form operand B in bits [63:32].
- An inter-byte timeout discards partial frames so the host can resynchronise after a dropped byte.

---
 rtl/uart_pkg.sv | 7 +
 rtl/rx_word_outreg.sv | 30 +++
 rtl/uart_rx_word_assembler.sv | 153 +++++++++++++++
 tb/tb_uart_rx_word_assembler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and byte/word default constants for the UART receive path.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} rx_asm_state_t;
    localparam int BYTE_W            = 8;
    localparam int NUM_BYTES_DEF     = 8;
    localparam int TIMEOUT_TICKS_DEF = 160;
endpackage

// File: rtl/rx_word_outreg.sv
// rx_word_outreg: holds the assembled word with valid/ready handshake and sticky overrun detection.
module rx_word_outreg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_word,
    input  logic         i_ready,
    output logic [W-1:0] o_word,
    output logic         o_valid,
    output logic         o_overrun
);
    logic w_accept;
    assign w_accept = !o_valid || i_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            o_word    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else if (i_load && w_accept) begin
            o_word  <= i_word;
            o_valid <= 1'b1;
        end else if (i_load) begin
            o_overrun <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler: packs NUM_BYTES received bytes little-endian into one word with timeout resync.
// Optional RX_CHECKSUM_EN adds a trailing XOR checksum byte (CHECK state, chk_err pulse).
module uart_rx_word_assembler
    import uart_pkg::*;
#(
    parameter int NUM_BYTES     = NUM_BYTES_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int CNT_W         = $clog2(NUM_BYTES + 1)
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [BYTE_W-1:0]           byte_in,
    input  logic                        byte_valid,
    output logic [NUM_BYTES*BYTE_W-1:0] word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        busy,
    output logic [CNT_W-1:0]            byte_count,
    output logic                        overrun,
    output logic                        timeout_err
`ifdef RX_CHECKSUM_EN
    ,
    output logic                        chk_err
`endif
);
    localparam int TICK_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int WORD_W = NUM_BYTES * BYTE_W;
`ifdef RX_CHECKSUM_EN
    localparam int STORE_N = NUM_BYTES;
`else
    // the last byte goes straight from byte_in into the output register
    localparam int STORE_N = NUM_BYTES - 1;
`endif

    rx_asm_state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
    logic [STORE_N*BYTE_W-1:0]   r_shift;
    logic [TICK_W-1:0]           r_tick_cnt;
    logic                        r_timeout_err;
    logic                        w_timeout, w_tmo_hit, w_load;
    logic [WORD_W-1:0]           w_word;
`ifdef RX_CHECKSUM_EN
    logic                        r_chk_err, w_chk_err;
    logic [BYTE_W-1:0]           w_xor;
    always_comb begin
        w_xor = '0;
        for (int k = 0; k < NUM_BYTES; k++) w_xor = w_xor ^ r_shift[BYTE_W*k +: BYTE_W];
    end
    assign w_word  = r_shift;
    assign chk_err = r_chk_err;
`else
    assign w_word = {byte_in, r_shift};
`endif

    assign w_tmo_hit = (r_tick_cnt == TICK_W'(TIMEOUT_TICKS)) && !byte_valid;

    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_timeout   = 1'b0;
`ifdef RX_CHECKSUM_EN
        w_chk_err   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (byte_valid) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid && r_cnt == CNT_W'(NUM_BYTES - 1)) begin
`ifdef RX_CHECKSUM_EN
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = CHECK;
`else
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
`endif
                end else if (byte_valid) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
`ifdef RX_CHECKSUM_EN
            CHECK: begin
                if (byte_valid) begin
                    w_load      = byte_in == w_xor;
                    w_chk_err   = byte_in != w_xor;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_shift       <= '0;
            r_tick_cnt    <= '0;
            r_timeout_err <= 1'b0;
`ifdef RX_CHECKSUM_EN
            r_chk_err     <= 1'b0;
`endif
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_timeout;
`ifdef RX_CHECKSUM_EN
            r_chk_err     <= w_chk_err;
`endif
            r_tick_cnt    <= (byte_valid || w_state_nxt == IDLE) ? '0 :
                             (tick && r_tick_cnt != TICK_W'(TIMEOUT_TICKS)) ? r_tick_cnt + 1'b1 : r_tick_cnt;
            for (int k = 0; k < STORE_N; k++)
                if (byte_valid && r_cnt == CNT_W'(k)) r_shift[BYTE_W*k +: BYTE_W] <= byte_in;
        end
    end

    assign byte_count  = r_cnt;
    assign busy        = r_cnt != '0;
    assign timeout_err = r_timeout_err;

    rx_word_outreg #(.W(WORD_W)) u_outreg (
        .clk       (sys_clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_word    (w_word),
        .i_ready   (word_ready),
        .o_word    (word_out),
        .o_valid   (word_valid),
        .o_overrun (overrun)
    );
endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// tb_uart_rx_word_assembler: directed checks of framing, handshake, timeout, overrun and reset.
module tb_uart_rx_word_assembler;
    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic [63:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        busy;
    logic [3:0]  byte_count;
    logic        overrun;
    logic        timeout_err;
`ifdef RX_CHECKSUM_EN
    logic        chk_err;
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    int n_checks = 0;
    int n_fail = 0;
    int n_tmo = 0;

    always #5 sys_clk = ~sys_clk;

    uart_rx_word_assembler dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .tick        (tick),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .byte_count  (byte_count),
        .overrun     (overrun),
        .timeout_err (timeout_err)
`ifdef RX_CHECKSUM_EN
        ,
        .chk_err     (chk_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic force_rdy);
        @(negedge sys_clk);
        byte_in = b;
        byte_valid = 1'b1;
        if (force_rdy) word_ready = 1'b1;
        @(negedge sys_clk);
        byte_valid = 1'b0;
        if (force_rdy) word_ready = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input logic rdy_last);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < 8; k++) begin
            x = x ^ w[8*k +: 8];
            send_byte(w[8*k +: 8], rdy_last && k == 7 && !CHK);
        end
        if (CHK) send_byte(x, rdy_last);
    endtask

    task automatic pulse_tick();
        @(negedge sys_clk);
        tick = 1'b1;
        if (timeout_err) n_tmo++;
        @(negedge sys_clk);
        tick = 1'b0;
        if (timeout_err) n_tmo++;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        check("rst_word", word_out, 64'h0);
        check("rst_valid", word_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", byte_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_tmo", timeout_err, 0);

        word_ready = 1'b1;
        send_word(64'h00000001_00000001, 1'b0);
        check("t1_valid", word_valid, 1);
        check("t1_word", word_out, 64'h00000001_00000001);
        check("t1_busy", busy, 0);
        @(negedge sys_clk);
        check("t1_consumed", word_valid, 0);

        word_ready = 1'b0;
        send_word(64'h5555555555555555, 1'b0);
        check("t2_valid", word_valid, 1);
        begin
            int bad;
            bad = 0;
            repeat (100) begin
                @(negedge sys_clk);
                if (word_out !== 64'h5555555555555555 || word_valid !== 1'b1) bad++;
            end
            check("t2_stable", bad, 0);
        end
        @(negedge sys_clk);
        word_ready = 1'b1;
        @(negedge sys_clk);
        word_ready = 1'b0;
        check("t2_cleared", word_valid, 0);

        word_ready = 1'b1;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        check("t3_count3", byte_count, 3);
        check("t3_busy", busy, 1);
        n_tmo = 0;
        for (int i = 0; i < 159; i++) pulse_tick();
        check("t3_no_early_tmo", n_tmo, 0);
        check("t3_count_held", byte_count, 3);
        pulse_tick();
        repeat (4) begin
            @(negedge sys_clk);
            if (timeout_err) n_tmo++;
        end
        check("t3_tmo_pulses", n_tmo, 1);
        check("t3_count0", byte_count, 0);
        check("t3_idle", busy, 0);
        send_word(64'hAAAAAAAAAAAAAAAA, 1'b0);
        check("t3_word", word_out, 64'hAAAAAAAAAAAAAAAA);
        check("t3_valid", word_valid, 1);

        @(negedge sys_clk);
        word_ready = 1'b0;
        send_word(64'h2222222222222222, 1'b0);
        check("t4_held", word_out, 64'h2222222222222222);
        send_word(64'h1111111111111111, 1'b0);
        check("t4_overrun", overrun, 1);
        check("t4_keep", word_out, 64'h2222222222222222);
        check("t4_valid", word_valid, 1);
        do_reset();
        check("t4_rst_overrun", overrun, 0);
        send_word(64'h2222222222222222, 1'b0);
        send_word(64'h1111111111111111, 1'b1);
        check("t4b_word", word_out, 64'h1111111111111111);
        check("t4b_valid", word_valid, 1);
        check("t4b_overrun", overrun, 0);

        for (int k = 0; k < 5; k++) send_byte(8'hFF, 1'b0);
        check("t5_count5", byte_count, 5);
        do_reset();
        check("t5_word", word_out, 64'h0);
        check("t5_valid", word_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_count", byte_count, 0);
        check("t5_overrun", overrun, 0);
        check("t5_tmo", timeout_err, 0);
        word_ready = 1'b1;
        send_word(64'h0807060504030201, 1'b0);
        check("t5_new_word", word_out, 64'h0807060504030201);
        check("t5_new_valid", word_valid, 1);

`ifdef RX_CHECKSUM_EN
        @(negedge sys_clk);
        for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b0);
        send_byte(8'h08, 1'b0);
        check("t6_ok_valid", word_valid, 1);
        check("t6_ok_chk", chk_err, 0);
        @(negedge sys_clk);
        for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b0);
        send_byte(8'h00, 1'b0);
        check("t6_bad_chk", chk_err, 1);
        check("t6_bad_valid", word_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
